// File: rtl/inst_window_fetch.sv
// Instruction prefetch window between a synchronous ROM and the cpu.
// Ports: Clk/Reset (sync, active-high); rom_address/rom_q drive one ROM
// port; redirect_valid/redirect_addr restart the stream; consume retires
// words from the head; window/window_addr/window_count present the head
// slots; stat_stall/stat_redirect are the optional counters enabled by
// INST_WINDOW_FETCH_STATS_EN (tied to 0 when the macro is undefined).
module inst_window_fetch #(
    parameter int INSTR_WIDTH        = 16,
    parameter int ROM_REGISTER_COUNT = 1024,
    parameter int WINDOW             = 4,
    parameter int DEPTH              = 8,
    localparam int AW = $clog2(ROM_REGISTER_COUNT),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int QW = $clog2(WINDOW + 1)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    output logic [AW-1:0]                 rom_address,
    input  logic [INSTR_WIDTH-1:0]        rom_q,
    input  logic                          redirect_valid,
    input  logic [AW-1:0]                 redirect_addr,
    input  logic [QW-1:0]                 consume,
    output logic [WINDOW*INSTR_WIDTH-1:0] window,
    output logic [AW-1:0]                 window_addr,
    output logic [CW-1:0]                 window_count,
    output logic [15:0]                   stat_stall,
    output logic [15:0]                   stat_redirect
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = CW + 1;

    logic [INSTR_WIDTH-1:0] buffer [DEPTH];
    logic [AW-1:0]          fetch_addr;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;
    logic                   inflight;
    logic                   inflight_epoch;
    logic                   epoch;

    logic [OW-1:0]          occupancy;
    logic                   issue;
    logic                   fill;
    logic                   epoch_next;
    logic [CW-1:0]          avail;
    logic [CW-1:0]          consume_eff;

    assign window_count = count;

    always_comb begin
        rom_address = redirect_valid ? redirect_addr : fetch_addr;
        epoch_next  = redirect_valid ? ~epoch : epoch;
        // Reserve a slot for the word already on its way back.
        occupancy   = OW'(count) + OW'(inflight);
        issue       = redirect_valid || (occupancy < OW'(DEPTH));
        // Stale-epoch words belong to a stream that was redirected away.
        fill        = inflight && !redirect_valid && (inflight_epoch == epoch);
        avail       = (count < CW'(WINDOW)) ? count : CW'(WINDOW);
        consume_eff = (CW'(consume) > avail) ? avail : CW'(consume);
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (CW'(i) < count) begin
                window[i*INSTR_WIDTH +: INSTR_WIDTH] = buffer[head + PW'(i)];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && fill) begin
            buffer[tail] <= rom_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_addr     <= '0;
            window_addr    <= '0;
            count          <= '0;
            head           <= '0;
            tail           <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_addr     <= rom_address + 1'b1;
                inflight_epoch <= epoch_next;
            end
            if (redirect_valid) begin
                epoch       <= epoch_next;
                count       <= '0;
                head        <= tail;
                window_addr <= redirect_addr;
            end else begin
                if (fill) begin
                    tail <= tail + 1'b1;
                end
                count       <= count + CW'(fill) - consume_eff;
                head        <= head + PW'(consume_eff);
                window_addr <= window_addr + AW'(consume_eff);
            end
        end
    end

`ifdef INST_WINDOW_FETCH_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] redir_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (count == '0 && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (redirect_valid && redir_q != 16'hFFFF) begin
                redir_q <= redir_q + 16'd1;
            end
        end
    end

    assign stat_stall    = stall_q;
    assign stat_redirect = redir_q;
`else
    assign stat_stall    = '0;
    assign stat_redirect = '0;
`endif

endmodule
